// File: rtl/pkt_stream_monitor_pkg.sv
// Shared definitions for the packet stream monitor: register map, FSM
// encoding, error codes and the EOP control decode.
package pkt_stream_monitor_pkg;

    localparam logic [7:0] HDR_CTRL_DEFAULT = 8'hFF;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_BP     = 3'd1;
    localparam logic [2:0] REG_PKT    = 3'd2;
    localparam logic [2:0] REG_WORD   = 3'd3;
    localparam logic [2:0] REG_BYTE   = 3'd4;
    localparam logic [2:0] REG_ERR    = 3'd5;
    localparam logic [2:0] REG_CHK    = 3'd6;
    localparam logic [2:0] REG_STATUS = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_OVERRUN  = 3'd1,
        ERR_NO_HDR   = 3'd2,
        ERR_TRUNC    = 3'd3,
        ERR_BAD_CTRL = 3'd4
    } err_t;

    // Valid byte count of an EOP word; bit k set means 8-k bytes, 0 if not one-hot.
    function automatic logic [3:0] onehot_to_bytes(input logic [7:0] ctrl);
        logic [3:0] nb;
        case (ctrl)
            8'h01:   nb = 4'd8;
            8'h02:   nb = 4'd7;
            8'h04:   nb = 4'd6;
            8'h08:   nb = 4'd5;
            8'h10:   nb = 4'd4;
            8'h20:   nb = 4'd3;
            8'h40:   nb = 4'd2;
            8'h80:   nb = 4'd1;
            default: nb = 4'd0;
        endcase
        return nb;
    endfunction

endpackage

// File: rtl/pkt_stream_monitor_regs.sv
// CPU-visible register file of the stream monitor: control bits, the
// back-pressure pattern and its rotating shadow, and the two-stage read path.
module pkt_stream_monitor_regs
    import pkt_stream_monitor_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  cpu_idx,
    input  logic [63:0] cpu_din,
    input  logic        cpu_wren,
    input  logic [31:0] pkt_cnt,
    input  logic [31:0] word_cnt,
    input  logic [31:0] byte_cnt,
    input  logic [31:0] err_cnt,
    input  logic [63:0] checksum,
    input  logic [1:0]  state,
    input  logic [2:0]  err_code,
    output logic        clr,
    output logic        rdy,
    output logic [63:0] cpu_dout
);

    logic        en_r;
    logic        bp_en_r;
    logic [31:0] bp_pattern_r;
    logic [31:0] pat_r;
    logic [2:0]  addr_r;
    logic [63:0] rd_data_s;
    logic        wr_ctrl_s;
    logic        wr_bp_s;
    logic        unused_s;

    assign wr_ctrl_s = cpu_wren & (cpu_idx == REG_CTRL);
    assign wr_bp_s   = cpu_wren & (cpu_idx == REG_BP);
    // CLR acts on the edge of the write itself so it wins over same-cycle increments.
    assign clr       = wr_ctrl_s & cpu_din[1];
    assign rdy       = en_r & (~bp_en_r | pat_r[0]);
    assign unused_s  = ^cpu_din[63:32];

    // Read mux over the address captured on the previous edge.
    always_comb begin
        rd_data_s = 64'd0;
        case (addr_r)
            REG_CTRL:   rd_data_s = {61'd0, bp_en_r, 1'b0, en_r};
            REG_BP:     rd_data_s = {32'd0, bp_pattern_r};
            REG_PKT:    rd_data_s = {32'd0, pkt_cnt};
            REG_WORD:   rd_data_s = {32'd0, word_cnt};
            REG_BYTE:   rd_data_s = {32'd0, byte_cnt};
            REG_ERR:    rd_data_s = {32'd0, err_cnt};
            REG_CHK:    rd_data_s = checksum;
            REG_STATUS: rd_data_s = {59'd0, err_code, state};
            default:    rd_data_s = 64'd0;
        endcase
    end

    // Register writes, pattern shadow rotation and registered read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_r         <= 1'b0;
            bp_en_r      <= 1'b0;
            bp_pattern_r <= 32'hFFFF_FFFF;
            pat_r        <= 32'hFFFF_FFFF;
            addr_r       <= 3'd0;
            cpu_dout     <= 64'd0;
        end else begin
            addr_r   <= cpu_idx;
            cpu_dout <= rd_data_s;
            if (wr_ctrl_s) begin
                en_r    <= cpu_din[0];
                bp_en_r <= cpu_din[2];
            end
            if (wr_bp_s) begin
                bp_pattern_r <= cpu_din[31:0];
                pat_r        <= cpu_din[31:0];
            end else if (bp_en_r) begin
                pat_r <= {pat_r[0], pat_r[31:1]};
            end
        end
    end

endmodule

// File: rtl/pkt_stream_monitor.sv
// Sink for a NetFPGA-style header/data/EOP word stream: tracks packet framing,
// counts packets, words, bytes and errors, and folds a per-packet XOR checksum.
module pkt_stream_monitor
    import pkt_stream_monitor_pkg::*;
#(
    parameter int         DATA_WIDTH = 64,
    parameter int         CTRL_WIDTH = 8,
    parameter logic [7:0] HDR_CTRL   = HDR_CTRL_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    input  logic [63:0]           cpu_ain,
    input  logic [63:0]           cpu_din,
    input  logic                  cpu_wren,
    output logic [63:0]           cpu_dout
);

    state_t                state_r, state_nx_s;
    logic [DATA_WIDTH-1:0] xor_r, xor_nx_s;
    logic [31:0]           pkt_bytes_r, bytes_nx_s;
    logic [31:0]           pkt_cnt_r, word_cnt_r, byte_cnt_r, err_cnt_r;
    logic [63:0]           checksum_r;
    logic [2:0]            err_code_r;
    logic                  rdy_s, clr_s, accept_s, overrun_s;
    logic                  is_hdr_s, is_data_s, is_eop_s;
    logic [3:0]            nb_s;
    logic [DATA_WIDTH-1:0] eop_mask_s;
    logic                  err_s, pkt_done_s, word_inc_s;
    err_t                  err_code_s;
    logic                  unused_s;

    assign in_rdy     = rdy_s;
    assign accept_s   = in_wr & rdy_s;
    assign overrun_s  = in_wr & ~rdy_s;
    assign is_hdr_s   = (in_ctrl == HDR_CTRL);
    assign is_data_s  = (in_ctrl == {CTRL_WIDTH{1'b0}});
    assign nb_s       = onehot_to_bytes(in_ctrl);
    assign is_eop_s   = ~is_hdr_s & (nb_s != 4'd0);
    // Valid EOP bytes sit at the top of the word; keep the first nb_s bytes.
    assign eop_mask_s = ~({DATA_WIDTH{1'b1}} >> {nb_s, 3'b000});
    assign word_inc_s = accept_s & (is_data_s | is_eop_s);
    assign unused_s   = ^cpu_ain[63:3];

    pkt_stream_monitor_regs u_regs (
        .clk      (clk),
        .rst      (rst),
        .cpu_idx  (cpu_ain[2:0]),
        .cpu_din  (cpu_din),
        .cpu_wren (cpu_wren),
        .pkt_cnt  (pkt_cnt_r),
        .word_cnt (word_cnt_r),
        .byte_cnt (byte_cnt_r),
        .err_cnt  (err_cnt_r),
        .checksum (checksum_r),
        .state    (state_r),
        .err_code (err_code_r),
        .clr      (clr_s),
        .rdy      (rdy_s),
        .cpu_dout (cpu_dout)
    );

    // Framing decisions for the word presented this cycle.
    always_comb begin
        state_nx_s  = state_r;
        xor_nx_s    = xor_r;
        bytes_nx_s  = pkt_bytes_r;
        err_s       = 1'b0;
        err_code_s  = ERR_NONE;
        pkt_done_s  = 1'b0;
        if (overrun_s) begin
            err_s      = 1'b1;
            err_code_s = ERR_OVERRUN;
        end else if (accept_s) begin
            if (is_hdr_s) begin
                case (state_r)
                    ST_IDLE: begin
                        state_nx_s = ST_HDR;
                        xor_nx_s   = {DATA_WIDTH{1'b0}};
                        bytes_nx_s = 32'd0;
                    end
                    ST_HDR:  state_nx_s = ST_HDR;
                    ST_DATA: begin
                        state_nx_s = ST_HDR;
                        xor_nx_s   = {DATA_WIDTH{1'b0}};
                        bytes_nx_s = 32'd0;
                        err_s      = 1'b1;
                        err_code_s = ERR_TRUNC;
                    end
                    default: state_nx_s = ST_IDLE;
                endcase
            end else if (is_data_s) begin
                case (state_r)
                    ST_HDR, ST_DATA: begin
                        state_nx_s = ST_DATA;
                        xor_nx_s   = xor_r ^ in_data;
                        bytes_nx_s = pkt_bytes_r + 32'd8;
                    end
                    ST_IDLE: begin
                        err_s      = 1'b1;
                        err_code_s = ERR_NO_HDR;
                    end
                    default: state_nx_s = ST_IDLE;
                endcase
            end else if (is_eop_s) begin
                case (state_r)
                    ST_HDR, ST_DATA: begin
                        state_nx_s = ST_IDLE;
                        xor_nx_s   = xor_r ^ (in_data & eop_mask_s);
                        bytes_nx_s = pkt_bytes_r + {28'd0, nb_s};
                        pkt_done_s = 1'b1;
                    end
                    ST_IDLE: begin
                        err_s      = 1'b1;
                        err_code_s = ERR_NO_HDR;
                    end
                    default: state_nx_s = ST_IDLE;
                endcase
            end else begin
                state_nx_s = ST_IDLE;
                err_s      = 1'b1;
                err_code_s = ERR_BAD_CTRL;
            end
        end else begin
            state_nx_s = state_r;
        end
    end

    // FSM, running packet state and the statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            xor_r       <= {DATA_WIDTH{1'b0}};
            pkt_bytes_r <= 32'd0;
            pkt_cnt_r   <= 32'd0;
            word_cnt_r  <= 32'd0;
            byte_cnt_r  <= 32'd0;
            err_cnt_r   <= 32'd0;
            checksum_r  <= 64'd0;
            err_code_r  <= 3'd0;
        end else begin
            state_r     <= state_nx_s;
            xor_r       <= xor_nx_s;
            pkt_bytes_r <= bytes_nx_s;
            if (clr_s) begin
                pkt_cnt_r  <= 32'd0;
                word_cnt_r <= 32'd0;
                byte_cnt_r <= 32'd0;
                err_cnt_r  <= 32'd0;
                checksum_r <= 64'd0;
                err_code_r <= 3'd0;
            end else begin
                if (pkt_done_s) begin
                    pkt_cnt_r  <= pkt_cnt_r + 32'd1;
                    byte_cnt_r <= byte_cnt_r + bytes_nx_s;
                    checksum_r <= xor_nx_s;
                end
                if (word_inc_s) begin
                    word_cnt_r <= word_cnt_r + 32'd1;
                end
                if (err_s) begin
                    err_cnt_r  <= err_cnt_r + 32'd1;
                    err_code_r <= err_code_s;
                end
            end
        end
    end

endmodule
